// File: rtl/valve_line_pkg.sv
// Shared types and constants for the valve board serial line master.
package valve_line_pkg;

    localparam int FRAME_BITS = 48;

    localparam logic SEN_IDLE   = 1'b0;
    localparam logic SCLK_IDLE  = 1'b0;
    localparam logic SDATA_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_TRAIL,
        ST_GAP
    } valve_line_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/valve_line_phase_timer.sv
// Loadable down-counter timing each FSM state; tick marks the last cycle of a state.
module valve_line_phase_timer
    import valve_line_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tick
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tick  = (count_q == '0);

endmodule

// File: rtl/valve_line_transmitter.sv
// Serial line master: shifts a 48-bit valve word out LSB first inside one line_sen window.
//
// state | meaning
// IDLE  | ready for a word, line at idle levels
// LEAD  | sen high, sdata high before bit 0
// SETUP | data presented ahead of the sclk rise
// HIGH  | sclk high; data held, then released high
// LOW   | sclk low, sdata high; shifts to next bit on exit
// TRAIL | sen high after the last bit
// GAP   | sen low spacing before the next frame
module valve_line_transmitter
    import valve_line_pkg::*;
#(
    parameter int QUARTER   = 3,
    parameter int LEAD_CYC  = 1,
    parameter int TRAIL_CYC = 1,
    parameter int GAP_CYC   = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [FRAME_BITS-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  line_sen,
    output logic                  line_sclk,
    output logic                  line_sdata,
    output logic                  busy,
    output logic                  frame_done
);

    if (QUARTER < 1 || LEAD_CYC < 1 || TRAIL_CYC < 1 || GAP_CYC < 1) begin : g_param_check
        $error("valve_line_transmitter: all timing parameters must be >= 1");
    end

    // The shared phase timer must hold the longest state duration, not only 2*QUARTER.
    localparam int MAX_DUR = max_int(max_int(2 * QUARTER, LEAD_CYC), max_int(TRAIL_CYC, GAP_CYC));
    localparam int PH_W    = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
    localparam int BIT_W   = 6;

    localparam logic [PH_W-1:0]  LEAD_LD  = PH_W'(LEAD_CYC - 1);
    localparam logic [PH_W-1:0]  QTR_LD   = PH_W'(QUARTER - 1);
    localparam logic [PH_W-1:0]  HIGH_LD  = PH_W'(2 * QUARTER - 1);
    localparam logic [PH_W-1:0]  TRAIL_LD = PH_W'(TRAIL_CYC - 1);
    localparam logic [PH_W-1:0]  GAP_LD   = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0]  HOLD_CMP = PH_W'(QUARTER);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    valve_line_state_t state_q, state_d;

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  busy_q, busy_d;
    logic                  sen_q, sen_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  done_q, done_d;

    logic                  ph_load;
    logic [PH_W-1:0]       ph_load_val;
    logic [PH_W-1:0]       ph_count;
    logic                  ph_tick;

    valve_line_phase_timer #(
        .W(PH_W)
    ) u_phase_timer (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .count    (ph_count),
        .tick     (ph_tick)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ph_load     = 1'b0;
        ph_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d     = ST_LEAD;
                    shift_d     = tx_data;
                    bit_cnt_d   = '0;
                    ph_load     = 1'b1;
                    ph_load_val = LEAD_LD;
                end
            end
            ST_LEAD: begin
                if (ph_tick) begin
                    state_d     = ST_SETUP;
                    ph_load     = 1'b1;
                    ph_load_val = QTR_LD;
                end
            end
            ST_SETUP: begin
                if (ph_tick) begin
                    state_d     = ST_HIGH;
                    ph_load     = 1'b1;
                    ph_load_val = HIGH_LD;
                end
            end
            ST_HIGH: begin
                if (ph_tick) begin
                    state_d     = ST_LOW;
                    ph_load     = 1'b1;
                    ph_load_val = QTR_LD;
                end
            end
            ST_LOW: begin
                if (ph_tick) begin
                    shift_d   = {1'b0, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    ph_load   = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d     = ST_TRAIL;
                        ph_load_val = TRAIL_LD;
                    end else begin
                        state_d     = ST_SETUP;
                        ph_load_val = QTR_LD;
                    end
                end
            end
            ST_TRAIL: begin
                if (ph_tick) begin
                    state_d     = ST_GAP;
                    ph_load     = 1'b1;
                    ph_load_val = GAP_LD;
                end
            end
            ST_GAP: begin
                if (ph_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line outputs follow the current state one cycle late, so every line pin is a flop.
    always_comb begin
        sen_d   = SEN_IDLE;
        sclk_d  = SCLK_IDLE;
        sdata_d = SDATA_IDLE;
        done_d  = 1'b0;

        case (state_q)
            ST_LEAD, ST_LOW, ST_TRAIL: begin
                sen_d = 1'b1;
            end
            ST_SETUP: begin
                sen_d   = 1'b1;
                sdata_d = shift_q[0];
            end
            ST_HIGH: begin
                sen_d  = 1'b1;
                sclk_d = 1'b1;
                if (ph_count >= HOLD_CMP) begin
                    sdata_d = shift_q[0];
                end
            end
            ST_GAP: begin
                done_d = (ph_count == GAP_LD);
            end
            default: begin
                sen_d = SEN_IDLE;
            end
        endcase
    end

    // Handshake flags track the next state so tx_ready never overlaps a started frame.
    assign tx_ready_d = (state_d == ST_IDLE);
    assign busy_d     = (state_d != ST_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            sen_q      <= SEN_IDLE;
            sclk_q     <= SCLK_IDLE;
            sdata_q    <= SDATA_IDLE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            sen_q      <= sen_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign line_sen   = sen_q;
    assign line_sclk  = sclk_q;
    assign line_sdata = sdata_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_valve_line_transmitter.sv
// Bench for valve_line_transmitter: table of words, scoreboard checked by a model line receiver.
module tb_valve_line_transmitter;

    localparam int QUARTER   = 3;
    localparam int LEAD_CYC  = 1;
    localparam int TRAIL_CYC = 1;
    localparam int GAP_CYC   = 2;
    localparam int SEN_LEN   = LEAD_CYC + 48 * 4 * QUARTER + TRAIL_CYC;

    typedef struct {
        logic [47:0] data;
        int          lows;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [47:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, line_sen, line_sclk, line_sdata, busy, frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    vec_t exp_q[$];

    // model receiver state
    bit          in_frame = 0;
    bit          sen_p = 0, sclk_p = 0, sdata_p = 1;
    logic [47:0] cap;
    int          nbits, len, lows, pulse_rises, first_sclk_len;
    bit          bad_pulse, rdy_bad;
    int          fall_cyc = 0, last_gap = 0, spurious_done = 0;

    valve_line_transmitter #(
        .QUARTER   (QUARTER),
        .LEAD_CYC  (LEAD_CYC),
        .TRAIL_CYC (TRAIL_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .line_sen   (line_sen),
        .line_sclk  (line_sclk),
        .line_sdata (line_sdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            exp_q.delete();
            in_frame = 0;
            sen_p    = 0;
            sclk_p   = 0;
            sdata_p  = 1;
        end else begin
            if (line_sen && !sen_p) begin
                in_frame       = 1;
                len            = 1;
                cap            = '0;
                nbits          = 0;
                lows           = 0;
                pulse_rises    = 0;
                first_sclk_len = 0;
                bad_pulse      = 0;
                rdy_bad        = tx_ready;
                last_gap       = cyc - fall_cyc;
            end else if (line_sen && in_frame) begin
                len++;
                if (tx_ready) rdy_bad = 1;
                if (!line_sdata && sdata_p) begin
                    lows++;
                    pulse_rises = 0;
                end
                if (line_sclk && !sclk_p) begin
                    if (nbits < 48) cap[nbits] = line_sdata;
                    if (nbits == 0) first_sclk_len = len;
                    nbits++;
                    if (!line_sdata) pulse_rises++;
                end
                if (line_sdata && !sdata_p && pulse_rises != 1) bad_pulse = 1;
            end else if (!line_sen && sen_p && in_frame) begin
                in_frame = 0;
                fall_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_frame", cap, 0);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    check(cap == e.data, "rx_word", cap, e.data);
                    check(nbits == 48, "sclk_rises", nbits, 48);
                    check(len == SEN_LEN, "sen_len", len, SEN_LEN);
                    check(lows == e.lows, "sdata_lows", lows, e.lows);
                    check(!bad_pulse, "pulse_span", bad_pulse, 0);
                    check(!rdy_bad, "ready_low", rdy_bad, 0);
                    check(frame_done == 1'b1, "frame_done", frame_done, 1);
                    check(first_sclk_len == LEAD_CYC + QUARTER + 1, "first_sclk", first_sclk_len,
                          LEAD_CYC + QUARTER + 1);
                end
            end
            if (frame_done && !(!line_sen && sen_p)) spurious_done++;
            sen_p   = line_sen;
            sclk_p  = line_sclk;
            sdata_p = line_sdata;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v, input bit keep);
        bit acc;
        acc      = 0;
        tx_data  = v.data;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge sys_clk);
            if (tx_ready && rst_n) begin
                acc = 1;
                exp_q.push_back(v);
            end
        end
        @(posedge sys_clk);
        #1;
        if (!keep) tx_valid = 1'b0;
        if (!acc) check(0, "accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !busy && !in_frame) done = 1;
        end
        if (!done) check(0, "idle_timeout", exp_q.size(), 0);
        @(posedge sys_clk);
        #1;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{48'h0000_0000_0001, 47};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 0};
        vecs[2] = '{48'h0000_0000_0000, 48};
        vecs[3] = '{48'hA5A5_0F0F_3C3C, 24};

        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            check({line_sen, line_sclk, line_sdata, tx_ready, busy, frame_done} == 6'b001000, "reset_hold",
                  {line_sen, line_sclk, line_sdata, tx_ready, busy, frame_done}, 6'b001000);
        end
        tx_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        #1;
        check(tx_ready == 1'b0, "ready_before_edge", tx_ready, 0);
        @(posedge sys_clk);
        #1;
        check(tx_ready == 1'b1, "ready_after_reset", tx_ready, 1);

        for (int i = 0; i < 4; i++) begin
            send(vecs[i], 1'b0);
            wait_idle();
        end

        send('{48'hA5A5_0F0F_3C3C, 24}, 1'b1);
        send('{48'h1234_5678_9ABC, 26}, 1'b0);
        wait_idle();
        check(last_gap == GAP_CYC + 1, "b2b_gap", last_gap, GAP_CYC + 1);

        send('{48'h0F0F_F0F0_1234, 27}, 1'b0);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 2000 && !hit; i++) begin
                @(negedge sys_clk);
                if (in_frame && nbits >= 21) hit = 1;
            end
            check(hit, "bit20_reached", nbits, 21);
        end
        @(posedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({line_sen, line_sclk, line_sdata} == 3'b001, "abort_levels",
              {line_sen, line_sclk, line_sdata}, 3'b001);
        check(busy == 1'b0, "abort_busy", busy, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        send('{48'h1234_5678_9ABC, 26}, 1'b0);
        wait_idle();

        check(spurious_done == 0, "spurious_done", spurious_done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
